histogram_accumulator: RTL and testbench

- Streaming intensity-histogram builder; sits directly upstream of the histogram derivative stage and feeds it.
- Consumes one 8-bit pixel per accepted beat over a valid/ready handshake, framed by start-of-frame and end-of-frame flags.
- Counts pixels into 256 saturating 16-bit bins.
- At end of frame, holds the completed histogram as a flat bus until the consumer acknowledges it, then clears all bins for the next frame.

---
 rtl/hist_pkg.sv | 23 ++
 rtl/sat_counter.sv | 39 +++
 rtl/histogram_accumulator.sv | 124 ++++++++++++
 tb/tb_histogram_accumulator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared constants, FSM state type and saturating-increment helper for the
// intensity-histogram builder.
package hist_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned BINS  = 2 ** PIX_W;
  localparam int unsigned BIN_W = 16;
  localparam int unsigned CNT_W = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } hist_state_t;

  // Returns val+1, clamped at 2**width-1; width must be below 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment in the
// same cycle load the value 1.
module sat_counter
  import hist_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MaxVal = '1;

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic [W-1:0] base;

  always_comb begin
    base    = clr_i ? '0 : value_q;
    value_d = inc_i ? W'(sat_inc(32'(base), W)) : base;
  end

  // Flags an increment that was lost because the counter was already full.
  assign sat_o   = inc_i & ~clr_i & (value_q == MaxVal);
  assign value_o = value_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/histogram_accumulator.sv
// Streaming 8-bit intensity histogram: counts framed pixels into saturating
// bins and holds the finished histogram until the consumer acknowledges it.
module histogram_accumulator
  import hist_pkg::*;
#(
  parameter int unsigned PIX_W = hist_pkg::PIX_W,
  parameter int unsigned BIN_W = hist_pkg::BIN_W,
  parameter int unsigned CNT_W = hist_pkg::CNT_W,
  parameter bit          TOP   = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_pix_valid,
  output logic                          o_pix_ready,
  input  logic [PIX_W-1:0]              i_pix,
  input  logic                          i_pix_sof,
  input  logic                          i_pix_eof,
  output logic [(2**PIX_W)*BIN_W-1:0]   o_histogram_flat,
  output logic                          o_hist_valid,
  input  logic                          i_hist_ack,
  output logic [CNT_W-1:0]              o_pix_count,
  output logic                          o_sat,
  output logic                          o_sync_err
);

  localparam int unsigned NumBins = 2 ** PIX_W;

  hist_state_t state_q;
  logic        pix_ready_q;
  logic        hist_valid_q;
  logic        sync_err_q;
  logic        sat_q;

  logic accept;
  logic count_en;
  logic clr_all;
  logic framing_err;
  logic cnt_sat;

  logic [NumBins-1:0][BIN_W-1:0] bin_val;
  logic [NumBins-1:0]            bin_sat;

  always_comb begin
    accept      = i_pix_valid & pix_ready_q;
    // A sof beat always starts a fresh frame, whether from idle or as a restart.
    count_en    = accept & (i_pix_sof | (state_q == S_ACCUM));
    framing_err = accept & (((state_q == S_IDLE) & ~i_pix_sof) |
                            ((state_q == S_ACCUM) & i_pix_sof));
    clr_all     = (accept & i_pix_sof) | ((state_q == S_HOLD) & i_hist_ack);
  end

  for (genvar j = 0; j < NumBins; j++) begin : g_bin
    sat_counter #(
      .W(BIN_W)
    ) u_bin (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .clr_i  (clr_all),
      .inc_i  (count_en & (i_pix == PIX_W'(j))),
      .value_o(bin_val[j]),
      .sat_o  (bin_sat[j])
    );
  end

  sat_counter #(
    .W(CNT_W)
  ) u_pix_count (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .clr_i  (clr_all),
    .inc_i  (count_en),
    .value_o(o_pix_count),
    .sat_o  (cnt_sat)
  );

  // Waveform capture for standalone runs is left to the simulation harness.
  if (TOP) begin : g_top_sim
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      pix_ready_q  <= 1'b1;
      hist_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      sync_err_q <= framing_err;
      sat_q      <= clr_all ? 1'b0 : (sat_q | cnt_sat | (|bin_sat));
      unique case (state_q)
        S_IDLE, S_ACCUM: begin
          if (count_en) begin
            if (i_pix_eof) begin
              state_q      <= S_HOLD;
              pix_ready_q  <= 1'b0;
              hist_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (i_hist_ack) begin
            state_q      <= S_IDLE;
            pix_ready_q  <= 1'b1;
            hist_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          pix_ready_q  <= 1'b1;
          hist_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_histogram_flat = bin_val;
  assign o_pix_ready      = pix_ready_q;
  assign o_hist_valid     = hist_valid_q;
  assign o_sync_err       = sync_err_q;
  assign o_sat            = sat_q;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Bench for histogram_accumulator: frame-level reference model checked every
// cycle, plus directed frames with hand-computed expectations.
module tb_histogram_accumulator;

  localparam int NB      = 256;
  localparam int BMAX    = 65535;
  localparam int CMAX    = (1 << 24) - 1;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_pix_valid;
  logic              o_pix_ready;
  logic [7:0]        i_pix;
  logic              i_pix_sof;
  logic              i_pix_eof;
  logic [NB*16-1:0]  o_histogram_flat;
  logic              o_hist_valid;
  logic              i_hist_ack;
  logic [23:0]       o_pix_count;
  logic              o_sat;
  logic              o_sync_err;

  histogram_accumulator dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_pix_valid     (i_pix_valid),
    .o_pix_ready     (o_pix_ready),
    .i_pix           (i_pix),
    .i_pix_sof       (i_pix_sof),
    .i_pix_eof       (i_pix_eof),
    .o_histogram_flat(o_histogram_flat),
    .o_hist_valid    (o_hist_valid),
    .i_hist_ack      (i_hist_ack),
    .o_pix_count     (o_pix_count),
    .o_sat           (o_sat),
    .o_sync_err      (o_sync_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame phase 0=waiting for sof, 1=in frame, 2=holding.
  int model_bins [NB];
  int model_count;
  bit model_sat;
  bit model_sync;
  int model_phase;
  bit model_live = 1'b0;

  function automatic int get_bin(input int j);
    return int'(o_histogram_flat[16*j +: 16]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < NB; j++) model_bins[j] = 0;
    model_count = 0;
    model_sat   = 1'b0;
  endtask

  task automatic model_count_pix(input int p);
    if (model_bins[p] == BMAX) model_sat = 1'b1;
    else model_bins[p]++;
    if (model_count == CMAX) model_sat = 1'b1;
    else model_count++;
  endtask

  task automatic model_step();
    model_sync = 1'b0;
    if (!i_rst_n) begin
      model_clear();
      model_phase = 0;
      model_live  = 1'b1;
    end else if (model_phase == 2) begin
      if (i_hist_ack) begin
        model_clear();
        model_phase = 0;
      end
    end else if (i_pix_valid) begin
      if (i_pix_sof) begin
        if (model_phase == 1) model_sync = 1'b1;
        model_clear();
        model_count_pix(int'(i_pix));
        model_phase = i_pix_eof ? 2 : 1;
      end else if (model_phase == 0) begin
        model_sync = 1'b1;
      end else begin
        model_count_pix(int'(i_pix));
        if (i_pix_eof) model_phase = 2;
      end
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge i_clk);
    if (model_live) begin
      int bad;
      bad = -1;
      check("pix_ready", 32'(o_pix_ready), 32'(model_phase != 2));
      check("hist_valid", 32'(o_hist_valid), 32'(model_phase == 2));
      check("sync_err", 32'(o_sync_err), 32'(model_sync));
      check("pix_count", 32'(o_pix_count), 32'(model_count));
      check("sat", 32'(o_sat), 32'(model_sat));
      for (int j = 0; j < NB; j++) begin
        if (bad < 0 && get_bin(j) != model_bins[j]) bad = j;
      end
      n_cmp++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL histogram bin %0d: got %0d, want %0d (t=%0t)",
                 bad, get_bin(bad), model_bins[bad], $time);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [7:0] p, input logic sof, input logic eof);
    @(negedge i_clk);
    i_pix_valid = 1'b1;
    i_pix       = p;
    i_pix_sof   = sof;
    i_pix_eof   = eof;
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_pix_valid = 1'b0;
    i_pix_sof   = 1'b0;
    i_pix_eof   = 1'b0;
    i_hist_ack  = 1'b0;
  endtask

  task automatic ack();
    @(negedge i_clk);
    i_pix_valid = 1'b0;
    i_hist_ack  = 1'b1;
    @(negedge i_clk);
    i_hist_ack  = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    int nz;
    nz = 0;
    for (int j = 0; j < NB; j++) if (get_bin(j) != 0) nz++;
    check(name, 32'(nz), 32'd0);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_pix_valid = 1'b0;
    i_pix       = '0;
    i_pix_sof   = 1'b0;
    i_pix_eof   = 1'b0;
    i_hist_ack  = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_ready", 32'(o_pix_ready), 32'd1);
    check("reset_valid", 32'(o_hist_valid), 32'd0);
    check("reset_count", 32'(o_pix_count), 32'd0);
    check_all_zero("reset_bins");
    i_rst_n = 1'b1;

    // Four-beat frame 3,3,3,200.
    drive(8'd3, 1'b1, 1'b0);
    drive(8'd3, 1'b0, 1'b0);
    drive(8'd3, 1'b0, 1'b0);
    drive(8'd200, 1'b0, 1'b1);
    idle();
    check("f1_valid", 32'(o_hist_valid), 32'd1);
    check("f1_ready", 32'(o_pix_ready), 32'd0);
    check("f1_bin3", 32'(get_bin(3)), 32'd3);
    check("f1_bin200", 32'(get_bin(200)), 32'd1);
    check("f1_count", 32'(o_pix_count), 32'd4);
    check("f1_model_bin3", 32'(model_bins[3]), 32'd3);
    // Beats offered while holding must be ignored.
    drive(8'd3, 1'b1, 1'b0);
    idle();
    check("f1_hold_bin3", 32'(get_bin(3)), 32'd3);
    check("f1_hold_ready", 32'(o_pix_ready), 32'd0);
    ack();
    check("f1_ack_ready", 32'(o_pix_ready), 32'd1);
    check("f1_ack_count", 32'(o_pix_count), 32'd0);

    // Single-beat frame; ack outside hold is ignored first.
    @(negedge i_clk);
    i_hist_ack = 1'b1;
    idle();
    drive(8'd0, 1'b1, 1'b1);
    idle();
    check("f2_bin0", 32'(get_bin(0)), 32'd1);
    check("f2_count", 32'(o_pix_count), 32'd1);
    check("f2_valid", 32'(o_hist_valid), 32'd1);
    ack();
    check_all_zero("f2_ack_bins");
    check("f2_ack_ready", 32'(o_pix_ready), 32'd1);

    // Non-sof beat in idle is dropped with a sync error.
    drive(8'd10, 1'b0, 1'b0);
    idle();
    check("idle_sync_err", 32'(o_sync_err), 32'd1);
    check_all_zero("idle_bins");
    idle();
    check("idle_sync_clr", 32'(o_sync_err), 32'd0);

    // Restart mid-frame after five pixels of 7.
    drive(8'd7, 1'b1, 1'b0);
    repeat (4) drive(8'd7, 1'b0, 1'b0);
    idle();
    check("rs_bin7", 32'(get_bin(7)), 32'd5);
    drive(8'd9, 1'b1, 1'b0);
    idle();
    check("rs_sync_err", 32'(o_sync_err), 32'd1);
    check("rs_bin9", 32'(get_bin(9)), 32'd1);
    check("rs_bin7_clr", 32'(get_bin(7)), 32'd0);
    check("rs_count", 32'(o_pix_count), 32'd1);
    drive(8'd9, 1'b0, 1'b1);
    idle();
    check("rs_bin9_end", 32'(get_bin(9)), 32'd2);
    ack();

    // Saturation: 65,537 back-to-back beats of 255.
    drive(8'd255, 1'b1, 1'b0);
    repeat (65535) drive(8'd255, 1'b0, 1'b0);
    drive(8'd255, 1'b0, 1'b1);
    idle();
    check("sat_bin255", 32'(get_bin(255)), 32'd65535);
    check("sat_flag", 32'(o_sat), 32'd1);
    check("sat_count", 32'(o_pix_count), 32'd65537);
    check("sat_model_count", 32'(model_count), 32'd65537);
    ack();
    check("sat_ack_flag", 32'(o_sat), 32'd0);

    // Reset while holding a frame of twelve 5s.
    drive(8'd5, 1'b1, 1'b0);
    repeat (10) drive(8'd5, 1'b0, 1'b0);
    drive(8'd5, 1'b0, 1'b1);
    idle();
    check("rh_bin5", 32'(get_bin(5)), 32'd12);
    check("rh_valid", 32'(o_hist_valid), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check_all_zero("rh_bins");
    check("rh_valid_clr", 32'(o_hist_valid), 32'd0);
    check("rh_ready", 32'(o_pix_ready), 32'd1);
    // Idle behaviour after reset: a non-sof beat must still be rejected.
    drive(8'd1, 1'b0, 1'b0);
    idle();
    check("rh_idle_sync", 32'(o_sync_err), 32'd1);
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
